// File: rtl/if_fetch_if.sv
// ============================================================================
//  Module   : if_fetch_if
//  Brief    : Instruction-memory request/response bus between fetch and IMEM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_data
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
//  Module   : if_fetch
//  Brief    : IF stage: PC, IMEM request FSM, one-word pending buffer, IF/ID.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        pc_write_i,
    input  wire logic        if_id_write_i,
    input  wire logic        branch_taken_i,
    input  wire logic [31:0] branch_target_i,
    if_fetch_if.master       imem,
    output logic      [31:0] inst_o,
    output logic      [31:0] pc_out_o,
    output logic             inst_valid_o,
    output logic             fetch_busy_o
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] pend_inst_q, pend_inst_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_out_q    <= 32'h0000_0000;
            valid_q     <= 1'b0;
            pend_inst_q <= 32'h0000_0000;
            pend_pc_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            pend_inst_q <= pend_inst_d;
            pend_pc_q   <= pend_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        pend_inst_d = pend_inst_q;
        pend_pc_d   = pend_pc_q;

        // A redirect overrides stalls, returning data and any buffered word.
        if (branch_taken_i) begin
            state_d     = S_FETCH;
            pc_d        = {branch_target_i[31:2], 2'b00};
            inst_d      = NOP_INST;
            valid_d     = 1'b0;
            pend_inst_d = 32'h0000_0000;
            pend_pc_d   = 32'h0000_0000;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem.imem_rdy) begin
                        if (if_id_write_i) begin
                            inst_d   = imem.imem_data;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                            if (pc_write_i) begin
                                pc_d = pc_q + 32'd4;
                            end
                        end else begin
                            pend_inst_d = imem.imem_data;
                            pend_pc_d   = pc_q;
                            state_d     = S_HOLD;
                        end
                    end else if (if_id_write_i) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (if_id_write_i) begin
                        inst_d   = pend_inst_q;
                        pc_out_d = pend_pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_FETCH;
                        if (pc_write_i) begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign fetch_busy_o   = (state_q == S_FETCH) && !imem.imem_rdy;
    assign inst_o         = inst_q;
    assign pc_out_o       = pc_out_q;
    assign inst_valid_o   = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
//  Module   : tb_if_fetch
//  Brief    : Scoreboard bench for if_fetch; IMEM model returns addr-derived words.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        fetch_busy;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (C_NOP)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_write_i      (pc_write),
        .if_id_write_i   (if_id_write),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .imem            (bus),
        .inst_o          (inst),
        .pc_out_o        (pc_out),
        .inst_valid_o    (inst_valid),
        .fetch_busy_o    (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    assign bus.imem_data = bus.imem_rdy ? word_at(bus.imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic rdy, input logic ifw, input logic pcw,
                          input logic br, input logic [31:0] tgt);
        @(negedge clk);
        bus.imem_rdy  = rdy;
        if_id_write   = ifw;
        pc_write      = pcw;
        branch_taken  = br;
        branch_target = tgt;
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p, input logic v);
        exp_t e;
        e.inst  = i;
        e.pc    = p;
        e.valid = v;
        sb.push_back(e);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_inst"},  inst,  e.inst);
            chk({tag, "_pcout"}, pc_out, e.pc);
            chk({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, e.valid});
        end
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr,
                           input logic busy);
        chk({tag, "_req"},  {31'd0, bus.imem_req}, {31'd0, req});
        chk({tag, "_addr"}, bus.imem_addr, addr);
        chk({tag, "_busy"}, {31'd0, fetch_busy}, {31'd0, busy});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.imem_rdy  = 1'b0;
        if_id_write   = 1'b1;
        pc_write      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst",  inst, C_NOP);
        chk("rst_pcout", pc_out, 32'h0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk_bus("rst", 1'b0 == 1'b0, 32'h0, 1'b1);

        // Streaming fetch: 0, 4, then stall on 8.
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("s0", 1'b1, 32'h0, 1'b0);
        push(word_at(32'h0), 32'h0, 1'b1);
        tick("s0");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("s4", 1'b1, 32'h4, 1'b0);
        push(word_at(32'h4), 32'h4, 1'b1);
        tick("s4");

        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk_bus("wait8", 1'b1, 32'h8, 1'b1);
            push(C_NOP, 32'h4, 1'b0);
            tick("wait8");
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("s8", 1'b1, 32'h8, 1'b0);
        push(word_at(32'h8), 32'h8, 1'b1);
        tick("s8");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        push(word_at(32'hC), 32'hC, 1'b1);
        tick("sC");

        // Stall with data returning at 0x10: word parks in the pending buffer.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_bus("h10a", 1'b1, 32'h10, 1'b0);
        push(word_at(32'hC), 32'hC, 1'b1);
        tick("h10a");
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_bus("h10b", 1'b0, 32'h10, 1'b0);
        push(word_at(32'hC), 32'hC, 1'b1);
        tick("h10b");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("h10rel", 1'b0, 32'h10, 1'b0);
        push(word_at(32'h10), 32'h10, 1'b1);
        tick("h10rel");

        // Park 0x14, then redirect to 0x103 while still stalled.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_bus("h14", 1'b1, 32'h14, 1'b0);
        push(word_at(32'h10), 32'h10, 1'b1);
        tick("h14");
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
        push(C_NOP, 32'h10, 1'b0);
        tick("br103");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("t100", 1'b1, 32'h100, 1'b0);
        push(word_at(32'h100), 32'h100, 1'b1);
        tick("t100");

        // PC wrap at the top of the address space.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        push(C_NOP, 32'h100, 1'b0);
        tick("brtop");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("top", 1'b1, 32'hFFFF_FFFC, 1'b0);
        push(word_at(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1);
        tick("top");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk_bus("wrap", 1'b1, 32'h0, 1'b0);

        // PC held while the word still enters IF/ID: same address refetched.
        push(word_at(32'h0), 32'h0, 1'b1);
        tick("pch0");
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("pch1", 1'b1, 32'h0, 1'b0);
        push(word_at(32'h0), 32'h0, 1'b1);
        tick("pch1");

        // Asynchronous reset in the middle of an outstanding fetch at 0x40.
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        push(C_NOP, 32'h0, 1'b0);
        tick("br40");
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("busy40", 1'b1, 32'h40, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_inst",  inst, C_NOP);
        chk("arst_pcout", pc_out, 32'h0);
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk_bus("arst", 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_bus("post", 1'b1, 32'h0, 1'b0);
        push(word_at(32'h0), 32'h0, 1'b1);
        tick("post");

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
